// File: rtl/code_shifter_pkg.sv
// Shared constants for the code_shifter variable-length code packer.
package code_shifter_pkg;

  localparam int DEFAULT_WIDTH = 16;

  // Fill-count width for a queue of 2*w bits (must hold the value 2*w).
  function automatic int cnt_width(input int w);
    return $clog2(2 * w) + 1;
  endfunction

endpackage

// File: rtl/code_shifter.sv
// Packs variable-length codes MSB-first into WIDTH-bit words, with flush support.
// Optional simulation checks are enabled by defining CODE_SHIFTER_ASSERT_EN.
module code_shifter
  import code_shifter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ena_in,
  output logic                   rdy_out,
  input  logic [WIDTH-1:0]       code,
  input  logic [$clog2(WIDTH):0] size,
  input  logic                   flush,
  output logic                   ena_out,
  input  logic                   rdy_in,
  output logic [WIDTH-1:0]       out
);

  localparam int CW = cnt_width(WIDTH);
  localparam int SW = $clog2(WIDTH) + 1;
  localparam int QW = 2 * WIDTH;
  localparam logic [CW-1:0] C_WIDTH = CW'(WIDTH);

  // Queue is MSB-justified: oldest bit at r_q[QW-1], bits below r_cnt stay zero.
  logic [QW-1:0]    r_q;
  logic [CW-1:0]    r_cnt;
  logic             r_pend;
  logic             r_rdy;
  logic             r_ena;
  logic [WIDTH-1:0] r_out;

  logic             w_accept;
  logic             w_free;
  logic             w_pend;
  logic             w_pend_next;
  logic [SW-1:0]    w_size_clamp;
  logic [CW-1:0]    w_size;
  logic [CW-1:0]    w_shamt;
  logic [CW-1:0]    w_cnt_app;
  logic [CW-1:0]    w_cnt_next;
  logic [QW-1:0]    w_code_ext;
  logic [QW-1:0]    w_q_app;
  logic [QW-1:0]    w_q_next;
  logic [WIDTH-1:0] w_out_next;
  logic             w_ena_next;

  assign w_accept     = ena_in && r_rdy;
  assign w_free       = !r_ena || rdy_in;
  assign w_pend       = r_pend || flush;
  assign w_size_clamp = (size > SW'(WIDTH)) ? SW'(WIDTH) : size;
  assign w_size       = CW'(w_size_clamp);
  assign w_code_ext   = {{WIDTH{1'b0}}, code} & ((QW'(1) << w_size) - QW'(1));
  assign w_shamt      = CW'(QW) - r_cnt - w_size;
  assign w_q_app      = r_q | (w_accept ? (w_code_ext << w_shamt) : '0);
  assign w_cnt_app    = r_cnt + (w_accept ? w_size : '0);

  always_comb begin
    w_q_next   = w_q_app;
    w_cnt_next = w_cnt_app;
    w_out_next = r_out;
    w_ena_next = r_ena;
    if (w_free) begin
      if (w_cnt_app >= C_WIDTH) begin
        w_out_next = w_q_app[QW-1 -: WIDTH];
        w_ena_next = 1'b1;
        w_q_next   = w_q_app << WIDTH;
        w_cnt_next = w_cnt_app - C_WIDTH;
      end else if (w_pend && (w_cnt_app != '0)) begin
        // Partial word: the zero bits below cnt provide the padding.
        w_out_next = w_q_app[QW-1 -: WIDTH];
        w_ena_next = 1'b1;
        w_q_next   = '0;
        w_cnt_next = '0;
      end else begin
        w_ena_next = 1'b0;
      end
    end
  end

  assign w_pend_next = w_pend && (w_cnt_next != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q    <= '0;
      r_cnt  <= '0;
      r_pend <= 1'b0;
      r_rdy  <= 1'b1;
      r_ena  <= 1'b0;
      r_out  <= '0;
    end else begin
      r_q    <= w_q_next;
      r_cnt  <= w_cnt_next;
      r_pend <= w_pend_next;
      r_rdy  <= (w_cnt_next < C_WIDTH) && !w_pend_next;
      r_ena  <= w_ena_next;
      r_out  <= w_out_next;
    end
  end

  assign rdy_out = r_rdy;
  assign ena_out = r_ena;
  assign out     = r_out;

`ifdef CODE_SHIFTER_ASSERT_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      a_size_range: assert (!(ena_in && (size > SW'(WIDTH))));
      a_cnt_range:  assert (r_cnt <= CW'(QW));
    end
  end
`endif

endmodule

// File: tb/tb_code_shifter.sv
// Directed bench for code_shifter: packing, flush, back-pressure and reset.
module tb_code_shifter;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             ena_in;
  logic             rdy_out;
  logic [WIDTH-1:0] code;
  logic [4:0]       size;
  logic             flush;
  logic             ena_out;
  logic             rdy_in;
  logic [WIDTH-1:0] out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  code_shifter #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .ena_in  (ena_in),
    .rdy_out (rdy_out),
    .code    (code),
    .size    (size),
    .flush   (flush),
    .ena_out (ena_out),
    .rdy_in  (rdy_in),
    .out     (out)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, act, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, act);
    end
  endtask

  // Advance one clock edge; inputs change and outputs are sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic [15:0] c, input logic [4:0] s, input logic fl);
    ena_in = en;
    code   = c;
    size   = s;
    flush  = fl;
  endtask

  initial begin
    rst = 1'b1;
    rdy_in = 1'b1;
    drive(1'b0, 16'h0, 5'd0, 1'b0);
    step();
    step();
    rst = 1'b0;
    check("rst_ena_out", 32'(ena_out), 32'd0);
    check("rst_out", 32'(out), 32'h0);
    check("rst_rdy_out", 32'(rdy_out), 32'd1);
    check("rst_cnt", 32'(dut.r_cnt), 32'd0);

    // Mixed-length packing across word boundaries.
    drive(1'b1, 16'h0401, 5'd11, 1'b0);
    step();
    check("pk1_ena_out", 32'(ena_out), 32'd0);
    check("pk1_cnt", 32'(dut.r_cnt), 32'd11);
    drive(1'b1, 16'h0041, 5'd7, 1'b0);
    step();
    check("pk2_ena_out", 32'(ena_out), 32'd1);
    check("pk2_out", 32'(out), 32'h8030);
    check("pk2_cnt", 32'(dut.r_cnt), 32'd2);
    drive(1'b1, 16'hAAAB, 5'd16, 1'b0);
    step();
    check("pk3_ena_out", 32'(ena_out), 32'd1);
    check("pk3_out", 32'(out), 32'h6AAA);
    check("pk3_cnt", 32'(dut.r_cnt), 32'd2);
    drive(1'b0, 16'h0, 5'd0, 1'b1);
    step();
    check("fl_ena_out", 32'(ena_out), 32'd1);
    check("fl_out", 32'(out), 32'hC000);
    check("fl_cnt", 32'(dut.r_cnt), 32'd0);
    drive(1'b0, 16'h0, 5'd0, 1'b0);
    step();
    check("fl_clear_ena", 32'(ena_out), 32'd0);
    check("fl_rdy_out", 32'(rdy_out), 32'd1);

    // Full word in one code, then idle.
    drive(1'b1, 16'hAAAB, 5'd16, 1'b0);
    step();
    check("full_ena_out", 32'(ena_out), 32'd1);
    check("full_out", 32'(out), 32'hAAAB);
    drive(1'b0, 16'h0, 5'd0, 1'b0);
    step();
    check("full_idle_ena", 32'(ena_out), 32'd0);

    // Empty flush and zero-length code.
    drive(1'b0, 16'h0, 5'd0, 1'b1);
    step();
    check("eflush_ena", 32'(ena_out), 32'd0);
    check("eflush_cnt", 32'(dut.r_cnt), 32'd0);
    drive(1'b1, 16'hFFFF, 5'd0, 1'b0);
    step();
    check("size0_ena", 32'(ena_out), 32'd0);
    check("size0_cnt", 32'(dut.r_cnt), 32'd0);
    check("size0_rdy", 32'(rdy_out), 32'd1);

    // Code appended on the same edge as flush.
    drive(1'b1, 16'h02AB, 5'd10, 1'b0);
    step();
    drive(1'b1, 16'h0005, 5'd3, 1'b1);
    step();
    check("afl_ena", 32'(ena_out), 32'd1);
    check("afl_out", 32'(out), 32'hAAE8);
    check("afl_cnt", 32'(dut.r_cnt), 32'd0);
    drive(1'b0, 16'h0, 5'd0, 1'b0);
    step();

    // Back-pressure while streaming 16-bit codes.
    rdy_in = 1'b0;
    drive(1'b1, 16'h1234, 5'd16, 1'b0);
    step();
    check("bp_a_out", 32'(out), 32'h1234);
    check("bp_a_ena", 32'(ena_out), 32'd1);
    drive(1'b1, 16'h5678, 5'd16, 1'b0);
    step();
    check("bp_b_out", 32'(out), 32'h1234);
    check("bp_b_rdy", 32'(rdy_out), 32'd0);
    check("bp_b_cnt", 32'(dut.r_cnt), 32'd16);
    drive(1'b1, 16'h9ABC, 5'd16, 1'b0);
    step();
    check("bp_c_out", 32'(out), 32'h1234);
    check("bp_c_ena", 32'(ena_out), 32'd1);
    check("bp_c_cnt", 32'(dut.r_cnt), 32'd16);
    rdy_in = 1'b1;
    step();
    check("bp_d_out", 32'(out), 32'h5678);
    check("bp_d_rdy", 32'(rdy_out), 32'd1);
    step();
    check("bp_e_out", 32'(out), 32'h9ABC);
    check("bp_e_ena", 32'(ena_out), 32'd1);
    drive(1'b0, 16'h0, 5'd0, 1'b0);
    step();
    check("bp_f_ena", 32'(ena_out), 32'd0);
    check("bp_f_cnt", 32'(dut.r_cnt), 32'd0);

    // Reset with a partial word queued.
    drive(1'b1, 16'h01FF, 5'd9, 1'b0);
    step();
    check("prst_cnt", 32'(dut.r_cnt), 32'd9);
    drive(1'b0, 16'h0, 5'd0, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mrst_ena", 32'(ena_out), 32'd0);
    check("mrst_cnt", 32'(dut.r_cnt), 32'd0);
    check("mrst_rdy", 32'(rdy_out), 32'd1);
    drive(1'b0, 16'h0, 5'd0, 1'b1);
    step();
    check("mrst_fl_ena", 32'(ena_out), 32'd0);
    drive(1'b0, 16'h0, 5'd0, 1'b0);
    step();
    check("mrst_fl2_ena", 32'(ena_out), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/code_shifter.md
CODE_SHIFTER -- requirements
Module: code_shifter

Interface
REQ-001 Parameter WIDTH, default 16, output word width and maximum code length in bits.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 ena_in  input  1  input code valid.
REQ-005 rdy_out  output  1  block can accept a code this cycle.
REQ-006 code  input  WIDTH  code value, right-justified; only the low `size` bits are meaningful.
REQ-007 size  input  $clog2(WIDTH)+1  number of valid code bits, 0..WIDTH.
REQ-008 flush  input  1  request to emit any partial word, zero-padded.
REQ-009 ena_out  output  1  output word valid.
REQ-010 rdy_in  input  1  downstream can accept the output word.
REQ-011 out  output  WIDTH  packed output word; the oldest bit is at the MSB.

Function
REQ-012 Accept: a code SHALL be accepted on a rising edge where ena_in=1 and rdy_out=1.
REQ-013 Append: an accepted code SHALL append code[size-1:0], MSB first, to an internal bit queue of capacity 2*WIDTH bits with fill count cnt.
REQ-014 Size range: size=0 SHALL be accepted and add no bits; size>WIDTH SHALL be treated as WIDTH.
REQ-015 Ready: rdy_out SHALL be a registered signal, 1 iff cnt<WIDTH and no flush is pending.
REQ-016 Output register: the output register is free iff ena_out=0 or rdy_in=1.
REQ-017 Full-word emit: on an edge where the output register is free and cnt (after the same-edge append) is >=WIDTH, the block SHALL load the oldest WIDTH bits into out, set ena_out=1, and reduce cnt by WIDTH.
REQ-018 Word latency: ena_out SHALL rise in the cycle after the accepting edge that completes the word.
REQ-019 Hold: with ena_out=1 and rdy_in=0, out and ena_out SHALL hold, and the queue SHALL keep accepting until rdy_out falls.
REQ-020 Clear: on an edge where the output register is free and nothing is loaded, ena_out SHALL clear to 0.
REQ-021 Flush latch: flush=1 SHALL set a pending flag; a code accepted on the same edge SHALL be appended before flushing.
REQ-022 Flush emit: while the flag is pending, each edge with a free output register SHALL emit the oldest min(cnt,WIDTH) bits left-justified, with the LSBs zero-padded.
REQ-023 Flush clear: the pending flag SHALL clear when cnt reaches 0.
REQ-024 Empty flush: flush with cnt=0 SHALL produce no output word.
REQ-025 Stream order: bit order SHALL be preserved exactly across word boundaries, with no gaps except the padding produced by a flush.

Reset
REQ-026 While rst=1 on an edge: cnt=0, queue=0, flush pending=0, ena_out=0, out=0, rdy_out=1 from the following cycle.
REQ-027 Reset mid-word or mid-flush SHALL discard all queued bits without emitting any output.

Configuration
REQ-028 Macro CODE_SHIFTER_ASSERT_EN defined: simulation assertions SHALL flag (a) ena_in=1 with size>WIDTH, and (b) cnt exceeding 2*WIDTH.
REQ-029 Macro CODE_SHIFTER_ASSERT_EN undefined: no assertions are compiled, and function SHALL be identical.

Structure
REQ-030 A shared package code_shifter_pkg SHALL hold the DEFAULT_WIDTH constant and a count-width function or constant ($clog2(2*WIDTH)+1).
REQ-031 code_shifter SHALL be a single module with no sub-module; queue, counter and output register are coded inline.

Verification
REQ-032 Codes (0x401,11), (0x41,7), (0xAAAB,16) on consecutive cycles, rdy_in=1 -> words 1000000000110000 then 0110101010101010; cnt=2 remains.
REQ-033 Then flush=1 for one cycle -> one word 1100000000000000, cnt=0.
REQ-034 Then (0xAAAB,16) followed by an idle cycle -> out=1010101010101011 one cycle after acceptance.
REQ-035 rdy_in=0 while streaming 16-bit codes -> out held stable, rdy_out falls once cnt>=16, no bits lost after rdy_in returns to 1.
REQ-036 flush with cnt=0, and a size=0 code -> no ena_out pulse, cnt unchanged.
REQ-037 rst asserted with cnt=9 -> ena_out=0, cnt=0; a following flush emits nothing.
